control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Multicycle control FSM for the MIPS-subset cpu datapath. Takes opcode/funct and ALU flags back from
//  the datapath; drives every datapath control line (PC/IR/reg/mem write enables, mux selects,
//  ALUControl, ShiftControl). One instance in cpu, sits beside the datapath. Handles opcode and overflow exceptions.
// PARAMETERS
//  MEM_WAIT   1             extra cycles between Memoria read issue and valid Dataout (>=1)
//  EXC_VEC    32'h0000_00FC exception handler address, driven on ExcAddr
// PORTS
//  clk        in   1  system clock; the only clock
//  reset      in   1  asynchronous, active-high reset
//  OPCODE     in   6  IR[31:26]
//  FUNCT      in   6  IR[5:0] (OFFSET[5:0])
//  Overflow   in   1  Ula32 flag
//  Igual      in   1  Ula32 A==B flag
//  PCwrite,MemWrite,MemRead,IRWrite,RegWrite,MemToReg,RegDest,AluSrcA,EPCWrite,IorD  out 1 each
//  AluSrcB    out  4  0:B 1:const 4 2:SignExt 3:SignExt<<2
//  PCSource   out  4  0:ALUResult 1:ALUout 2:JumpAddress 3:EPCout 4:ExcAddr
//  ALUControl out  3  000 passA,001 add,010 sub,011 and,111 compare
//  ShiftControl out 3 000 hold,001 load,010 sll,011 srl
//  ExcAddr    out 32  constant EXC_VEC
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (clk / reset).
//  Reset: state<=RST; all 1-bit outputs 0, selects 0, ALUControl=000, ShiftControl=000. Outputs are Moore (decoded from state + latched opcode), except branch PCwrite.
//  Reset mid-instruction aborts; no partial write completes after reset rises.
//  RST -> FETCH (1 cycle, all outputs idle).
//  FETCH: IorD=0, MemRead=1, AluSrcA=0, AluSrcB=1, ALUControl=001, PCSource=0, PCwrite=1 (PC<=PC+4).
//  FWAIT: counter MEM_WAIT..1; on count==1 assert IRWrite=1, next DECODE. Counter reloads in every WAIT entry.
//  DECODE: AluSrcA=0, AluSrcB=3, ALUControl=001 (ALUout<=branch target); A/B load. Dispatch:
//   op 00 funct 20/22/24 -> EXEC_R; op 00 funct 00 -> SHL; op 08 -> EXEC_I; op 23/2B -> MADDR;
//   op 04/05 -> BRANCH; op 02 -> JUMP; any other op/funct -> EXC_OP.
//  EXEC_R: AluSrcA=1, AluSrcB=0, ALUControl add/sub/and per funct; if Overflow=1 and funct!=24 -> EXC_OVF else WB_R.
//  WB_R: RegDest=1, MemToReg=0, RegWrite=1 -> FETCH.  EXEC_I: AluSrcA=1, AluSrcB=2, add; Overflow -> EXC_OVF else WB_I (RegDest=0, RegWrite=1).
//  MADDR: AluSrcA=1, AluSrcB=2, add -> lw: MRD / sw: MWR.
//  MRD: IorD=1, MemRead=1 -> MWAIT (MEM_WAIT cycles) -> MWB: MemToReg=1, RegDest=0, RegWrite=1 -> FETCH.
//  MWR: IorD=1, MemWrite=1 for exactly 1 cycle -> FETCH.
//  BRANCH: AluSrcA=1, AluSrcB=0, ALUControl=111, PCSource=1; PCwrite=Igual (beq) / !Igual (bne) -> FETCH.
//  JUMP: PCSource=2, PCwrite=1 -> FETCH.  SHL: ShiftControl=001 -> SHOP: 010 -> SHWB: RegDest=1, RegWrite=1 (shift path via MemToReg=0 WriteSrc) -> FETCH.
//  EXC_OP/EXC_OVF: AluSrcA=0, AluSrcB=1, ALUControl=010, EPCWrite=1 (EPC<=PC-4) -> EXC_JMP: PCSource=4, PCwrite=1 -> FETCH.
//  Overflow exceptions never assert RegWrite. Overflow ignored outside EXEC_R/EXEC_I.
//  Never assert MemWrite and MemRead together; RegWrite and PCwrite never together except none.
//  State register 5 bits, wait counter $clog2(MEM_WAIT+1) bits; saturates, no wrap.
// STRUCTURE
//  Shared include cpu_defs.vh: opcode/funct constants, ALUControl, ShiftControl, AluSrcB and PCSource codes, state encodings (shared with cpu datapath).
//  Single module; no sub-modules. Next-state logic and output decode in separate always blocks.
// TESTING
//  add (op00 f20), Overflow=0 -> FETCH,FWAIT,DECODE,EXEC_R,WB_R; RegWrite=1,RegDest=1 only in WB_R; 5 cycles @MEM_WAIT=1.
//  lw (op23), MEM_WAIT=3 -> IRWrite one cycle after 3 FWAIT cycles; MemToReg=1,RegWrite=1 in MWB only.
//  beq Igual=1 -> PCwrite=1,PCSource=1 in BRANCH; Igual=0 -> PCwrite=0; bne inverse.
//  op 3F -> EXC_OP: EPCWrite=1, ALUControl=010; next PCwrite=1,PCSource=4, ExcAddr=32'hFC; RegWrite never 1.
//  addi with Overflow=1 in EXEC_I -> EXC_OVF, no RegWrite; sw -> MemWrite=1 exactly 1 cycle, IorD=1.
//  reset asserted mid-MWAIT -> outputs zero immediately (async); after release RST then FETCH.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit and its datapath:
// opcode/funct values, ALU/shift/mux select codes, FSM state encoding, and the
// decode-stage dispatch helper.
package control_unit_pkg;

  // Opcode field values, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct field values for R-type, IR[5:0]
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ALUControl codes
  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_CMP   = 3'b111;

  // ShiftControl codes
  localparam logic [2:0] SH_HOLD = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;

  // AluSrcB mux selects
  localparam logic [3:0] SRCB_B       = 4'd0;
  localparam logic [3:0] SRCB_FOUR    = 4'd1;
  localparam logic [3:0] SRCB_SEXT    = 4'd2;
  localparam logic [3:0] SRCB_SEXT_S2 = 4'd3;

  // PCSource mux selects
  localparam logic [3:0] PCS_ALURES = 4'd0;
  localparam logic [3:0] PCS_ALUOUT = 4'd1;
  localparam logic [3:0] PCS_JUMP   = 4'd2;
  localparam logic [3:0] PCS_EPC    = 4'd3;
  localparam logic [3:0] PCS_EXC    = 4'd4;

  // FSM state encoding
  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_FWAIT, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MADDR, S_MRD, S_MWAIT, S_MWB, S_MWR,
    S_BRANCH, S_JUMP,
    S_SHL, S_SHOP, S_SHWB,
    S_EXC_OP, S_EXC_OVF, S_EXC_JMP
  } state_t;

  // Decode-stage dispatch: anything not recognised traps as an opcode exception
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    nxt = S_EXC_OP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND: nxt = S_EXEC_R;
          FN_SLL:                 nxt = S_SHL;
          default:                nxt = S_EXC_OP;
        endcase
      end
      OP_ADDI:       nxt = S_EXEC_I;
      OP_LW, OP_SW:  nxt = S_MADDR;
      OP_BEQ, OP_BNE: nxt = S_BRANCH;
      OP_J:          nxt = S_JUMP;
      default:       nxt = S_EXC_OP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset cpu: drives every datapath control line
// from the current state plus the opcode/funct latched in DECODE (branch PCwrite also
// follows Igual). Memory waits last MEM_WAIT cycles; opcode and overflow traps jump to EXC_VEC.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int          MEM_WAIT = 1,
  parameter logic [31:0] EXC_VEC  = 32'h0000_00FC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OPCODE,
  input  logic [5:0]  FUNCT,
  input  logic        Overflow,
  input  logic        Igual,
  output logic        PCwrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        RegDest,
  output logic        AluSrcA,
  output logic        EPCWrite,
  output logic        IorD,
  output logic [3:0]  AluSrcB,
  output logic [3:0]  PCSource,
  output logic [2:0]  ALUControl,
  output logic [2:0]  ShiftControl,
  output logic [31:0] ExcAddr
);

  localparam int CW = $clog2(MEM_WAIT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [5:0]      op_q, funct_q;
  logic            wait_done;

  // Last wait cycle; "<=" keeps a stuck zero count from hanging the FSM
  assign wait_done = (cnt_q <= CW'(1));
  assign ExcAddr   = EXC_VEC;

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   state_d = S_FWAIT;
      S_FWAIT:   state_d = wait_done ? S_DECODE : S_FWAIT;
      S_DECODE:  state_d = dispatch(OPCODE, FUNCT);
      S_EXEC_R:  state_d = (Overflow && (funct_q != FN_AND)) ? S_EXC_OVF : S_WB_R;
      S_EXEC_I:  state_d = Overflow ? S_EXC_OVF : S_WB_I;
      S_MADDR:   state_d = (op_q == OP_LW) ? S_MRD : S_MWR;
      S_MRD:     state_d = S_MWAIT;
      S_MWAIT:   state_d = wait_done ? S_MWB : S_MWAIT;
      S_SHL:     state_d = S_SHOP;
      S_SHOP:    state_d = S_SHWB;
      S_EXC_OP,
      S_EXC_OVF: state_d = S_EXC_JMP;
      S_WB_R, S_WB_I, S_MWB, S_MWR,
      S_BRANCH, S_JUMP, S_SHWB,
      S_EXC_JMP: state_d = S_FETCH;
      default:   state_d = S_RST;
    endcase
  end

  // State, wait counter and instruction-field registers; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      // Reload on every entry to a wait state, otherwise count down and stick at zero
      if ((state_d == S_FWAIT || state_d == S_MWAIT) && (state_d != state_q))
        cnt_q <= CW'(MEM_WAIT);
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CW'(1);
      // IR is stable in DECODE; keep our own copy for the later states
      if (state_q == S_DECODE) begin
        op_q    <= OPCODE;
        funct_q <= FUNCT;
      end
    end
  end

  // Control line decode from current state (idle everywhere not listed)
  always_comb begin
    PCwrite      = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemToReg     = 1'b0;
    RegDest      = 1'b0;
    AluSrcA      = 1'b0;
    EPCWrite     = 1'b0;
    IorD         = 1'b0;
    AluSrcB      = SRCB_B;
    PCSource     = PCS_ALURES;
    ALUControl   = ALU_PASSA;
    ShiftControl = SH_HOLD;
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        AluSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSource   = PCS_ALURES;
        PCwrite    = 1'b1;
      end
      S_FWAIT:  IRWrite = wait_done;
      S_DECODE: begin
        AluSrcB    = SRCB_SEXT_S2;
        ALUControl = ALU_ADD;
      end
      S_EXEC_R: begin
        AluSrcA = 1'b1;
        case (funct_q)
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      S_WB_R: begin
        RegDest  = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I, S_MADDR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = SRCB_SEXT;
        ALUControl = ALU_ADD;
      end
      S_WB_I: RegWrite = 1'b1;
      S_MRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      // Address mux stays on ALUout while the memory finishes the read
      S_MWAIT: IorD = 1'b1;
      S_MWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA    = 1'b1;
        ALUControl = ALU_CMP;
        PCSource   = PCS_ALUOUT;
        PCwrite    = (op_q == OP_BNE) ? !Igual : Igual;
      end
      S_JUMP: begin
        PCSource = PCS_JUMP;
        PCwrite  = 1'b1;
      end
      S_SHL:  ShiftControl = SH_LOAD;
      S_SHOP: ShiftControl = SH_SLL;
      S_SHWB: begin
        RegDest  = 1'b1;
        RegWrite = 1'b1;
      end
      // EPC <= PC - 4 rewinds to the faulting instruction
      S_EXC_OP, S_EXC_OVF: begin
        AluSrcB    = SRCB_FOUR;
        ALUControl = ALU_SUB;
        EPCWrite   = 1'b1;
      end
      S_EXC_JMP: begin
        PCSource = PCS_EXC;
        PCwrite  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
